cluster_finder_iter: RTL

Parametrised successor to the GEM chamber S-bit cluster packer. It accepts one chamber frame of S-bits per strobe, maps the VFATs onto eta partitions and marks cluster starts with their sizes. An iterative state machine then extracts up to MXCLUSTERS clusters in priority order, one per clock. It sits between the S-bit deserialisers and the trigger-link formatter. Unlike the fixed packer, it reports overflow and busy status and counts frames it had to drop.

---
 rtl/cluster_pkg.sv | 52 +++++
 rtl/cluster_priority_encoder.sv | 25 ++
 rtl/cluster_finder_iter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cluster_pkg.sv
// Shared constants, types and helpers for the iterative GEM S-bit cluster finder.
package cluster_pkg;

    localparam int DEF_MXSBITS    = 64;
    localparam int DEF_MXVFATS    = 24;
    localparam int DEF_MXROWS     = 8;
    localparam int DEF_MXCLUSTERS = 8;
    localparam int DEF_MXCNTBITS  = 3;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_MXKEYS    = DEF_MXSBITS * DEF_MXVFATS / DEF_MXROWS;
    localparam int DEF_MXADRBITS = clog2(DEF_MXKEYS * DEF_MXROWS + 1);

    localparam logic [DEF_MXADRBITS-1:0] INVALID_ADR = '1;

    typedef struct packed {
        logic [DEF_MXCNTBITS-1:0] cnt;
        logic [DEF_MXADRBITS-1:0] adr;
    } cluster_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Length of the unbroken run of ones starting at bit 0, looking at no more than cap bits.
    function automatic int count_consecutive(input logic [31:0] above, input int cap);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int j = 0; j < 32; j++) begin
            if (j < cap) begin
                run = run & above[j];
                if (run) n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/cluster_priority_encoder.sv
// Find-first-set over the cluster-start mask; reverse=1 searches from the top address down.
module cluster_priority_encoder #(
    parameter int WIDTH = 1536,
    parameter int IDX_W = 11
) (
    input  logic [WIDTH-1:0] mask,
    input  logic             reverse,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && mask[reverse ? WIDTH - 1 - i : i]) begin
                found = 1'b1;
                index = IDX_W'(reverse ? WIDTH - 1 - i : i);
            end
        end
    end

endmodule

// File: rtl/cluster_finder_iter.sv
// Iterative S-bit cluster finder: one frame in, up to MXCLUSTERS clusters out, one per clock.
// Optional build macro REVERSE_PRIORITY_EN adds reverse_priority (highest address first).
module cluster_finder_iter
    import cluster_pkg::*;
#(
    parameter  int MXSBITS    = DEF_MXSBITS,
    parameter  int MXVFATS    = DEF_MXVFATS,
    parameter  int MXROWS     = DEF_MXROWS,
    parameter  int MXCLUSTERS = DEF_MXCLUSTERS,
    parameter  int MXCNTBITS  = DEF_MXCNTBITS,
    localparam int MXKEYS     = MXSBITS * MXVFATS / MXROWS,
    localparam int MXADRBITS  = clog2(MXKEYS * MXROWS + 1)
) (
    input  logic                                         clock4x,
    input  logic                                         global_reset,
    input  logic [MXSBITS*MXVFATS-1:0]                   sbits,
    input  logic                                         sbits_valid,
    input  logic                                         truncate_clusters,
`ifdef REVERSE_PRIORITY_EN
    input  logic                                         reverse_priority,
`endif
    output logic [MXCLUSTERS*(MXCNTBITS+MXADRBITS)-1:0]  clusters,
    output logic                                         clusters_valid,
    output logic                                         cluster_overflow,
    output logic                                         busy,
    output logic [15:0]                                  dropped_cnt
);

    localparam int NADR   = MXKEYS * MXROWS;
    localparam int L      = 2 ** MXCNTBITS;
    localparam int SLOT_W = MXCNTBITS + MXADRBITS;
    localparam int IDX_W  = (MXCLUSTERS > 1) ? clog2(MXCLUSTERS) : 1;
    localparam logic [SLOT_W-1:0] INVALID_SLOT = {{MXCNTBITS{1'b0}}, {MXADRBITS{1'b1}}};

    state_t state, next_state;

    logic [MXSBITS*MXVFATS-1:0] sbits_q;
    logic                       trunc_q;
    logic                       rev_sel;

    logic [NADR-1:0]            frame_bits;
    logic [NADR-1:0]            vpf;
    logic [MXCNTBITS-1:0]       cnt_comb [NADR];

    logic [NADR-1:0]            mask_q;
    logic [MXCNTBITS-1:0]       cnt_q [NADR];
    logic [NADR-1:0]            mask_rem;
    logic                       rem_nz;

    logic [MXCLUSTERS*SLOT_W-1:0] slots;
    logic [IDX_W-1:0]           idx;

    logic                       enc_found;
    logic [MXADRBITS-1:0]       enc_idx;

    logic accept, load, write, done_now, drop;

`ifdef REVERSE_PRIORITY_EN
    logic rev_q;
    assign rev_sel = rev_q;
`else
    assign rev_sel = 1'b0;
`endif

    // Re-order the chamber frame into row-major address space: address = row*MXKEYS + key.
    always_comb begin
        frame_bits = '0;
        for (int v = 0; v < MXVFATS; v++) begin
            for (int b = 0; b < MXSBITS; b++) begin
                frame_bits[(v % MXROWS) * MXKEYS + (v / MXROWS) * MXSBITS + b] = sbits_q[v * MXSBITS + b];
            end
        end
    end

    always_comb begin
        vpf      = '0;
        cnt_comb = '{default: '0};
        for (int r = 0; r < MXROWS; r++) begin
            for (int k = 0; k < MXKEYS; k++) begin
                int          a;
                logic        start;
                logic        run;
                logic [31:0] above;
                a     = r * MXKEYS + k;
                run   = 1'b0;
                if (k == 0) start = frame_bits[a];
                else        start = frame_bits[a] && !frame_bits[a-1];
                // A run longer than L is split: a second cluster starts right after the first L bits.
                if (!trunc_q && k >= L) begin
                    run = frame_bits[a];
                    for (int j = 1; j <= L; j++) run = run & frame_bits[a-j];
                    if (k - L - 1 >= 0) run = run & !frame_bits[a-L-1];
                    start = start | run;
                end
                above = '0;
                for (int j = 1; j < L; j++) begin
                    if (k + j < MXKEYS) above[j-1] = frame_bits[a+j];
                end
                vpf[a]      = start;
                cnt_comb[a] = MXCNTBITS'(count_consecutive(above, L - 1));
            end
        end
    end

    cluster_priority_encoder #(
        .WIDTH (NADR),
        .IDX_W (MXADRBITS)
    ) u_pri (
        .mask    (mask_q),
        .reverse (rev_sel),
        .found   (enc_found),
        .index   (enc_idx)
    );

    always_comb begin
        mask_rem          = mask_q;
        mask_rem[enc_idx] = 1'b0;
    end
    assign rem_nz = |mask_rem;

    assign busy = (state == ST_COUNT) || (state == ST_SCAN);
    assign drop = sbits_valid && busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) state <= ST_IDLE;
        else              state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        write      = 1'b0;
        done_now   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sbits_valid) begin
                    accept     = 1'b1;
                    next_state = ST_COUNT;
                end
            end
            ST_COUNT: begin
                load       = 1'b1;
                next_state = ST_SCAN;
            end
            ST_SCAN: begin
                if (!enc_found) begin
                    next_state = ST_DONE;
                end else begin
                    write = 1'b1;
                    if (!rem_nz || int'(idx) == MXCLUSTERS - 1) next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done_now = 1'b1;
                if (sbits_valid) begin
                    accept     = 1'b1;
                    next_state = ST_COUNT;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: the frame copy and count array carry no reset; they are only read after a
    // fresh accept/load, so clearing them would cost reset fan-out for nothing.
    always_ff @(posedge clock4x) begin
        if (accept) begin
            sbits_q <= sbits;
            trunc_q <= truncate_clusters;
`ifdef REVERSE_PRIORITY_EN
            rev_q   <= reverse_priority;
`endif
        end
        if (load) cnt_q <= cnt_comb;
    end

    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            mask_q           <= '0;
            slots            <= {MXCLUSTERS{INVALID_SLOT}};
            idx              <= '0;
            clusters         <= {MXCLUSTERS{INVALID_SLOT}};
            clusters_valid   <= 1'b0;
            cluster_overflow <= 1'b0;
            dropped_cnt      <= '0;
        end else begin
            clusters_valid <= done_now;
            if (load) begin
                mask_q <= vpf;
                slots  <= {MXCLUSTERS{INVALID_SLOT}};
                idx    <= '0;
            end
            if (write) begin
                slots[int'(idx) * SLOT_W +: SLOT_W] <= {cnt_q[enc_idx], enc_idx};
                mask_q[enc_idx] <= 1'b0;
                idx             <= idx + 1'b1;
            end
            if (done_now) begin
                clusters         <= slots;
                cluster_overflow <= |mask_q;
            end
            if (drop && dropped_cnt != 16'hFFFF) dropped_cnt <= dropped_cnt + 16'd1;
        end
    end

endmodule
